// File: rtl/seq_gen_pkg.sv
// Shared types and default sizing for the serial pattern generator.
// SEQ_GEN_PARITY_EN adds the PARITY state for the trailing even-parity bit.
package seq_gen_pkg;

  localparam int unsigned MAX_LEN_D = 8;
  localparam int unsigned LEN_W_D   = 5;
  localparam int unsigned REP_W_D   = 4;
  localparam int unsigned GAP_W_D   = 3;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GAP,
    DONE
`ifdef SEQ_GEN_PARITY_EN
    , PARITY
`endif
  } state_t;

endpackage

// File: rtl/seq_gen_shifter.sv
// Loadable MSB-aligned shift register with a down-counting bit index.
// With SEQ_GEN_PARITY_EN it also keeps a running XOR of the emitted bits.
module seq_gen_shifter
  import seq_gen_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_D,
  parameter int unsigned LEN_W   = LEN_W_D
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic [MAX_LEN-1:0] i_pattern,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_first,
  output logic               o_next,
  output logic               o_last
`ifdef SEQ_GEN_PARITY_EN
  , output logic             o_par
`endif
);

  logic [MAX_LEN-1:0] w_aligned;
  logic [MAX_LEN-1:0] r_sr;
  logic [LEN_W-1:0]   r_idx;

  // Bit len-1 lands in the MSB; r_sr holds only the bits still to come.
  assign w_aligned = i_pattern << (LEN_W'(MAX_LEN) - i_len);
  assign o_first   = w_aligned[MAX_LEN-1];
  assign o_next    = r_sr[MAX_LEN-1];
  assign o_last    = (r_idx == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr  <= '0;
      r_idx <= '0;
    end else if (i_load) begin
      r_sr  <= w_aligned << 1;
      r_idx <= i_len - LEN_W'(1);
    end else if (i_shift) begin
      r_sr  <= r_sr << 1;
      r_idx <= r_idx - LEN_W'(1);
    end
  end

`ifdef SEQ_GEN_PARITY_EN
  logic r_par;

  assign o_par = r_par;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_par <= 1'b0;
    end else if (i_load) begin
      r_par <= w_aligned[MAX_LEN-1];
    end else if (i_shift) begin
      r_par <= r_par ^ r_sr[MAX_LEN-1];
    end
  end
`endif

endmodule

// File: rtl/seq_gen_pattern.sv
// Bit-serial pattern transmitter: MSB-first, repeatable with idle gaps.
// Optional SEQ_GEN_PARITY_EN appends an even-parity bit to every repetition.
module seq_gen_pattern
  import seq_gen_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_D,
  parameter int unsigned LEN_W   = LEN_W_D,
  parameter int unsigned REP_W   = REP_W_D,
  parameter int unsigned GAP_W   = GAP_W_D
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [REP_W-1:0]   repeat_n,
  input  logic [GAP_W-1:0]   gap,
  output logic               out_bit,
  output logic               out_valid,
  output logic               ready,
  output logic               done
);

  state_t r_state, w_state_nxt;

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic [REP_W-1:0]   r_rep;
  logic [GAP_W-1:0]   r_gap_cfg;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_out_bit, r_out_valid, r_ready, r_done;

  logic               w_len_ok;
  logic [MAX_LEN-1:0] w_src_pat;
  logic [LEN_W-1:0]   w_src_len;
  logic               w_first, w_next, w_last;
  logic               w_accept, w_reload, w_shift, w_rep_end, w_rep_dec;
  logic               w_gap_load, w_gap_dec;
  logic               w_bit_nxt, w_valid_nxt, w_done_nxt;
`ifdef SEQ_GEN_PARITY_EN
  logic               w_par;
`endif

  assign w_len_ok  = (len != '0) && (len <= LEN_W'(MAX_LEN));
  // Acceptance loads straight from the inputs; repetitions reload the captured copy.
  assign w_src_pat = (r_state == IDLE) ? pattern : r_pat;
  assign w_src_len = (r_state == IDLE) ? len : r_len;

  seq_gen_shifter #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_accept | w_reload),
    .i_shift   (w_shift),
    .i_pattern (w_src_pat),
    .i_len     (w_src_len),
    .o_first   (w_first),
    .o_next    (w_next),
    .o_last    (w_last)
`ifdef SEQ_GEN_PARITY_EN
    , .o_par   (w_par)
`endif
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reload    = 1'b0;
    w_shift     = 1'b0;
    w_rep_end   = 1'b0;
    w_rep_dec   = 1'b0;
    w_gap_load  = 1'b0;
    w_gap_dec   = 1'b0;
    w_bit_nxt   = 1'b0;
    w_valid_nxt = 1'b0;
    w_done_nxt  = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start && w_len_ok) begin
          w_accept    = 1'b1;
          w_state_nxt = SEND;
          w_bit_nxt   = w_first;
          w_valid_nxt = 1'b1;
        end
      end
      SEND: begin
        if (!w_last) begin
          w_shift     = 1'b1;
          w_bit_nxt   = w_next;
          w_valid_nxt = 1'b1;
        end else begin
`ifdef SEQ_GEN_PARITY_EN
          w_state_nxt = PARITY;
          w_bit_nxt   = w_par;
          w_valid_nxt = 1'b1;
`else
          w_rep_end   = 1'b1;
`endif
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      PARITY: w_rep_end = 1'b1;
`endif
      GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt = SEND;
          w_reload    = 1'b1;
          w_bit_nxt   = w_first;
          w_valid_nxt = 1'b1;
        end else begin
          w_gap_dec = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // End of one repetition: gap, seamless restart, or finish.
    if (w_rep_end) begin
      if (r_rep != '0) begin
        w_rep_dec = 1'b1;
        if (r_gap_cfg != '0) begin
          w_state_nxt = GAP;
          w_gap_load  = 1'b1;
        end else begin
          w_state_nxt = SEND;
          w_reload    = 1'b1;
          w_bit_nxt   = w_first;
          w_valid_nxt = 1'b1;
        end
      end else begin
        w_state_nxt = DONE;
        w_done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_out_bit   <= 1'b0;
      r_out_valid <= 1'b0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_pat       <= '0;
      r_len       <= '0;
      r_rep       <= '0;
      r_gap_cfg   <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_bit   <= w_bit_nxt;
      r_out_valid <= w_valid_nxt;
      r_ready     <= (w_state_nxt == IDLE);
      r_done      <= w_done_nxt;
      if (w_accept) begin
        r_pat     <= pattern;
        r_len     <= len;
        r_rep     <= repeat_n;
        r_gap_cfg <= gap;
      end
      if (w_rep_dec) begin
        r_rep <= r_rep - REP_W'(1);
      end
      // Loaded with gap-1 so the terminal compare at zero gives exactly gap idle cycles.
      if (w_gap_load) begin
        r_gap_cnt <= r_gap_cfg - GAP_W'(1);
      end else if (w_gap_dec) begin
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end
    end
  end

  assign out_bit   = r_out_bit;
  assign out_valid = r_out_valid;
  assign ready     = r_ready;
  assign done      = r_done;

endmodule

// File: tb/tb_seq_gen_pattern.sv
// Directed bench for seq_gen_pattern; expected streams are hand-written per build
// ('1'/'0' valid bit, '-' gap cycle, 'D' done cycle).
module tb_seq_gen_pattern;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] pattern;
  logic [4:0] len;
  logic [3:0] repeat_n;
  logic [2:0] gap;
  logic       out_bit, out_valid, ready, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_gen_pattern #(
    .MAX_LEN (8),
    .LEN_W   (5),
    .REP_W   (4),
    .GAP_W   (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .repeat_n  (repeat_n),
    .gap       (gap),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .ready     (ready),
    .done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {out_valid, out_bit, done, ready} expected for one stream symbol.
  function automatic logic [3:0] code(input byte c);
    case (c)
      "1":     return 4'b1100;
      "0":     return 4'b1000;
      "-":     return 4'b0000;
      "D":     return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic launch(input logic [7:0] p, input logic [4:0] l,
                        input logic [3:0] r, input logic [2:0] g);
    pattern  = p;
    len      = l;
    repeat_n = r;
    gap      = g;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    pattern = '0; len = '0; repeat_n = '0; gap = '0;
    tick();
    tick();
    total++;
    if ({out_valid, out_bit, done, ready} !== 4'b0001) begin
      bad++;
      $display("FAIL reset_state got=%b want=0001", {out_valid, out_bit, done, ready});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    string s;
`ifdef SEQ_GEN_PARITY_EN
    s = "10111D";
`else
    s = "1011D";
`endif
    launch(8'h0B, 5'd4, 4'd0, 3'd0);
    for (int i = 0; i < s.len(); i++) begin
      total++;
      if ({out_valid, out_bit, done, ready} !== code(s[i])) begin
        bad++;
        $display("FAIL single cyc%0d got=%b want=%b", i + 1, {out_valid, out_bit, done, ready}, code(s[i]));
      end
      tick();
    end
    total++;
    if ({out_valid, out_bit, done, ready} !== 4'b0001) begin
      bad++;
      $display("FAIL single_idle got=%b want=0001", {out_valid, out_bit, done, ready});
    end
  endtask

  task automatic test_repeat_gap();
    string s;
`ifdef SEQ_GEN_PARITY_EN
    s = "10111--10111--10111D";
`else
    s = "1011--1011--1011D";
`endif
    launch(8'h0B, 5'd4, 4'd2, 3'd2);
    for (int i = 0; i < s.len(); i++) begin
      total++;
      if ({out_valid, out_bit, done, ready} !== code(s[i])) begin
        bad++;
        $display("FAIL rep_gap cyc%0d got=%b want=%b", i + 1, {out_valid, out_bit, done, ready}, code(s[i]));
      end
      tick();
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL rep_gap_busy_len ready=%b want=1", ready);
    end
  endtask

  task automatic test_back_to_back();
    string      s;
    logic [3:0] sh   = '0;
    int         hits = 0;
`ifdef SEQ_GEN_PARITY_EN
    s = "1011110111D";
`else
    s = "10111011D";
`endif
    launch(8'h0B, 5'd4, 4'd1, 3'd0);
    for (int i = 0; i < s.len(); i++) begin
      total++;
      if ({out_valid, out_bit, done, ready} !== code(s[i])) begin
        bad++;
        $display("FAIL b2b cyc%0d got=%b want=%b", i + 1, {out_valid, out_bit, done, ready}, code(s[i]));
      end
      if (out_valid === 1'b1) begin
        sh = {sh[2:0], out_bit};
        if (sh == 4'b1011) hits++;
      end
      tick();
    end
    total++;
    if (hits !== 2) begin
      bad++;
      $display("FAIL b2b_detector hits=%0d want=2", hits);
    end
  endtask

  task automatic test_ignore_start();
    string s;
`ifdef SEQ_GEN_PARITY_EN
    s = "10111D";
`else
    s = "1011D";
`endif
    launch(8'h0B, 5'd4, 4'd0, 3'd0);
    for (int i = 0; i < s.len(); i++) begin
      total++;
      if ({out_valid, out_bit, done, ready} !== code(s[i])) begin
        bad++;
        $display("FAIL ignore_start cyc%0d got=%b want=%b", i + 1, {out_valid, out_bit, done, ready}, code(s[i]));
      end
      if (i == 0) begin
        start = 1'b1; pattern = 8'h04; len = 5'd3; repeat_n = 4'd3; gap = 3'd1;
      end
      if (i == 2) start = 1'b0;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({out_valid, done, ready} !== 3'b001) begin
        bad++;
        $display("FAIL ignore_start_idle%0d got=%b want=001", i, {out_valid, done, ready});
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    string s;
    launch(8'h0B, 5'd4, 4'd1, 3'd1);
    tick();
    tick();
    total++;
    if ({out_valid, out_bit} !== 2'b11) begin
      bad++;
      $display("FAIL reset_mid_bit3 got=%b want=11", {out_valid, out_bit});
    end
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    total++;
    if ({out_valid, out_bit, done, ready} !== 4'b0001) begin
      bad++;
      $display("FAIL reset_mid_after got=%b want=0001", {out_valid, out_bit, done, ready});
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if ({out_valid, done, ready} !== 3'b001) begin
        bad++;
        $display("FAIL reset_mid_quiet%0d got=%b want=001", i, {out_valid, done, ready});
      end
    end
`ifdef SEQ_GEN_PARITY_EN
    s = "1100D";
`else
    s = "110D";
`endif
    launch(8'hF6, 5'd3, 4'd0, 3'd0);
    for (int i = 0; i < s.len(); i++) begin
      total++;
      if ({out_valid, out_bit, done, ready} !== code(s[i])) begin
        bad++;
        $display("FAIL reset_mid_fresh cyc%0d got=%b want=%b", i + 1, {out_valid, out_bit, done, ready}, code(s[i]));
      end
      tick();
    end
  endtask

  task automatic test_bad_len();
    pattern = 8'h0B; repeat_n = '0; gap = '0;
    len = 5'd0;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) len = 5'd9;
      tick();
      total++;
      if ({out_valid, done, ready} !== 3'b001) begin
        bad++;
        $display("FAIL bad_len%0d len=%0d got=%b want=001", i, len, {out_valid, done, ready});
      end
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_len_bounds();
    string s;
`ifdef SEQ_GEN_PARITY_EN
    s = "101001111D";
`else
    s = "10100111D";
`endif
    launch(8'hA7, 5'd8, 4'd0, 3'd0);
    for (int i = 0; i < s.len(); i++) begin
      total++;
      if ({out_valid, out_bit, done, ready} !== code(s[i])) begin
        bad++;
        $display("FAIL max_len cyc%0d got=%b want=%b", i + 1, {out_valid, out_bit, done, ready}, code(s[i]));
      end
      tick();
    end
`ifdef SEQ_GEN_PARITY_EN
    s = "1010D";
`else
    s = "101D";
`endif
    launch(8'hF5, 5'd3, 4'd0, 3'd0);
    for (int i = 0; i < s.len(); i++) begin
      total++;
      if ({out_valid, out_bit, done, ready} !== code(s[i])) begin
        bad++;
        $display("FAIL upper_bits cyc%0d got=%b want=%b", i + 1, {out_valid, out_bit, done, ready}, code(s[i]));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat_gap();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_bad_len();
    test_len_bounds();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
